pid_loop_sequencer: RTL and testbench
=====================================

Name: pid_loop_sequencer

Overview:
Sequences the closed-loop speed controller inside tt_um_top_motor_control. Each sample period it:
- captures the encoder position and derives a velocity;
- forms the speed error;
- runs the shared PID datapath through a start/done handshake;
- converts the signed PID output into PWM duty magnitude and direction.

It also supervises the PID datapath for timeout and sample overrun, forcing the motor off on fault.

Parameters:
SAMPLE_DIV, 50000, sample period in clk cycles (min 8)
CNT_W, 16, encoder, velocity, error and PID output width (signed two's complement)
DUTY_W, 8, PWM duty magnitude width
TIMEOUT, 64, max cycles waiting for pid_done before fault

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock domain, asynchronous, active-high
ena  in  1  loop run enable
setpoint  in  CNT_W  signed target velocity, counts per sample
enc_count  in  CNT_W  free-running encoder position, wraps modulo 2^CNT_W
pid_start  out  1  one-cycle start pulse to PID datapath
pid_error  out  CNT_W  signed error, held from COMPUTE until next COMPUTE
pid_done  in  1  one-cycle completion pulse from PID datapath
pid_u  in  CNT_W  signed PID output, valid when pid_done=1
duty  out  DUTY_W  PWM magnitude
dir  out  1  1 = reverse (pid_u negative)
duty_valid  out  1  one-cycle pulse when duty/dir update
sample_tick  out  1  one-cycle pulse every SAMPLE_DIV cycles while running
fault  out  1  PID timeout latched
overrun_cnt  out  8  saturating count of dropped ticks

Behaviour:
- Reset (async, immediate): state IDLE, all outputs 0, tick counter 0, prev_enc 0.
- Tick counter:
  - Runs only when state is not IDLE/FAULT; counts 0..SAMPLE_DIV-1.
  - sample_tick=1 when count==SAMPLE_DIV-1, then wraps.
  - Held at 0 in IDLE.
- FSM states: IDLE, WAIT_TICK, CAPTURE, COMPUTE, WAIT_PID, APPLY, FAULT.
- IDLE:
  - duty=0, dir=0.
  - ena=1 -> WAIT_TICK; prev_enc <= enc_count (prime, so first velocity is 0-based).
- WAIT_TICK: sample_tick in cycle k -> CAPTURE in cycle k+1.
- CAPTURE: vel <= enc_count - prev_enc (modular CNT_W subtract, wrap-correct); prev_enc <= enc_count; -> COMPUTE.
- COMPUTE (cycle k+2):
  - pid_error <= sat(setpoint - vel), computed CNT_W+1 bits, saturated to [-2^(CNT_W-1), 2^(CNT_W-1)-1].
  - pid_start=1 combinationally from state; pid_error register updates on the same edge into COMPUTE, so it is valid while pid_start=1.
  - Timeout counter cleared; -> WAIT_PID.
- WAIT_PID:
  - pid_done=1 -> latch pid_u, -> APPLY.
  - Otherwise timeout counter increments; reaching TIMEOUT -> FAULT.
  - pid_done on the same cycle as expiry: done wins.
- APPLY:
  - dir <= pid_u[CNT_W-1]; duty <= min(|pid_u|, 2^DUTY_W-1). |most-negative| saturates.
  - duty_valid=1 in the cycle after APPLY, coincident with new duty/dir.
  - -> WAIT_TICK.
- FAULT: fault=1, duty=0, dir=0, no pid_start; stays until ena=0.
- ena=0 in any state -> IDLE next edge:
  - duty/dir <= 0; fault cleared.
  - In-flight pid_done is ignored.
- pid_done outside WAIT_PID: ignored.
- Overrun: sample_tick while state is not WAIT_TICK -> tick dropped; overrun_cnt increments, saturating at 255. Cleared only by rst.
- Latency: tick to pid_start = 2 cycles; pid_done to duty_valid = 2 cycles.

Decomposition:
- Package motor_ctrl_pkg holds:
  - state enum;
  - CNT_W/DUTY_W defaults;
  - sat_signed (CNT_W+1 -> CNT_W) function;
  - abs_sat (CNT_W -> DUTY_W) function.
- Sub-module sample_timer (SAMPLE_DIV counter, run/clear inputs, tick output), instantiated once.

Test Plan:
- Basic loop (SAMPLE_DIV=100, TIMEOUT=16): ena=1, setpoint=20, enc_count static. First tick -> pid_start 2 cycles later with pid_error=20. Responder returns pid_u=-300 after 3 cycles -> duty=255, dir=1, duty_valid pulse 2 cycles after pid_done.
- Wrap: prev_enc=0xFFF0, enc_count=0x0010 at tick, setpoint=40 -> vel=+32, pid_error=8. pid_u=100 -> duty=100, dir=0.
- Saturation: setpoint=32767, vel=-100 -> pid_error=32767. pid_u=-32768 -> duty=255, dir=1.
- Timeout: no pid_done for 16 cycles -> fault=1, duty=0, no further pid_start. ena=0 -> IDLE, fault=0. pid_done arriving on the 16th cycle instead -> APPLY, fault stays 0.
- Overrun: SAMPLE_DIV=8, TIMEOUT=64, responder delay 10 cycles -> overrun_cnt increments once per dropped tick; loop continues; duty updates each completed cycle.
- Reset mid-operation: assert rst between clock edges during WAIT_PID -> outputs 0 and state IDLE immediately. Release, ena=1 -> first pid_error uses a primed prev_enc (vel=0).

Source files
------------

// File: rtl/motor_ctrl_pkg.sv
// Shared types and helpers for the motor speed-loop sequencer.
// Holds the FSM state encoding and the saturation functions.
package motor_ctrl_pkg;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_DUTY_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_CAPTURE,
    ST_COMPUTE,
    ST_WAIT_PID,
    ST_APPLY,
    ST_FAULT
  } state_e;

  // Clamp a widened signed value into a w-bit signed range.
  function automatic logic signed [31:0] sat_signed(
    input logic signed [31:0] x,
    input int unsigned        w
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Magnitude of a signed value, clamped to a w-bit unsigned range.
  function automatic logic [31:0] abs_sat(
    input logic signed [31:0] x,
    input int unsigned        w
  );
    logic [31:0] mag;
    logic [31:0] top;
    mag = x[31] ? 32'(-x) : 32'(x);
    top = (32'd1 << w) - 32'd1;
    return (mag > top) ? top : mag;
  endfunction

endpackage

// File: rtl/pid_loop_sequencer_sample_timer.sv
// Sample-period divider for the speed loop.
// Counts while running, parks at zero when cleared.
module sample_timer #(
  parameter int SAMPLE_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(SAMPLE_DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise wrap at the last count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick_o = run_i && (cnt_q == LAST);

endmodule

// File: rtl/pid_loop_sequencer.sv
// Per-sample sequencer for the closed-loop speed controller.
// Drives the shared PID datapath and supervises it for faults.
module pid_loop_sequencer
  import motor_ctrl_pkg::*;
#(
  parameter int SAMPLE_DIV = 50000,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int DUTY_W     = DEF_DUTY_W,
  parameter int TIMEOUT    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic signed [CNT_W-1:0] setpoint,
  input  logic        [CNT_W-1:0] enc_count,
  output logic                    pid_start,
  output logic signed [CNT_W-1:0] pid_error,
  input  logic                    pid_done,
  input  logic signed [CNT_W-1:0] pid_u,
  output logic       [DUTY_W-1:0] duty,
  output logic                    dir,
  output logic                    duty_valid,
  output logic                    sample_tick,
  output logic                    fault,
  output logic              [7:0] overrun_cnt
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_e                  state_q, state_d;
  logic        [CNT_W-1:0] prev_q, prev_d;
  logic signed [CNT_W-1:0] err_q, err_d;
  logic signed [CNT_W-1:0] pu_q, pu_d;
  logic        [TMO_W-1:0] tmo_q, tmo_d;
  logic       [DUTY_W-1:0] duty_q, duty_d;
  logic                    dir_q, dir_d;
  logic                    dval_q, dval_d;
  logic                    fault_q, fault_d;
  logic              [7:0] ovr_q, ovr_d;

  logic                    tick;
  logic                    run;
  logic signed [CNT_W-1:0] vel;
  logic signed [31:0]      err_w;

  assign run = (state_q != ST_IDLE) && (state_q != ST_FAULT);

  sample_timer #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run_i  (run),
    .clr_i  (!run),
    .tick_o (tick)
  );

  // Next-state and datapath updates; ena low overrides everything.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    err_d   = err_q;
    pu_d    = pu_q;
    tmo_d   = tmo_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    dval_d  = 1'b0;
    ovr_d   = ovr_q;
    vel     = enc_count - prev_q;
    err_w   = 32'(setpoint) - 32'(vel);

    unique case (state_q)
      ST_IDLE: begin
        duty_d = '0;
        dir_d  = 1'b0;
        if (ena) begin
          state_d = ST_WAIT_TICK;
          prev_d  = enc_count;
        end
      end
      ST_WAIT_TICK: begin
        if (tick) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        prev_d  = enc_count;
        err_d   = CNT_W'(sat_signed(err_w, CNT_W));
        state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        tmo_d   = '0;
        state_d = ST_WAIT_PID;
      end
      ST_WAIT_PID: begin
        if (pid_done) begin
          pu_d    = pid_u;
          state_d = ST_APPLY;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_q == TMO_W'(TIMEOUT - 1)) state_d = ST_FAULT;
        end
      end
      ST_APPLY: begin
        duty_d  = DUTY_W'(abs_sat(32'(pu_q), DUTY_W));
        dir_d   = pu_q[CNT_W-1];
        dval_d  = 1'b1;
        state_d = ST_WAIT_TICK;
      end
      ST_FAULT: begin
        duty_d = '0;
        dir_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!ena) begin
      state_d = ST_IDLE;
      duty_d  = '0;
      dir_d   = 1'b0;
      dval_d  = 1'b0;
    end

    if (state_d == ST_FAULT) begin
      duty_d = '0;
      dir_d  = 1'b0;
    end

    fault_d = (state_d == ST_FAULT);

    if (tick && (state_q != ST_WAIT_TICK) && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prev_q  <= '0;
      err_q   <= '0;
      pu_q    <= '0;
      tmo_q   <= '0;
      duty_q  <= '0;
      dir_q   <= 1'b0;
      dval_q  <= 1'b0;
      fault_q <= 1'b0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      err_q   <= err_d;
      pu_q    <= pu_d;
      tmo_q   <= tmo_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      dval_q  <= dval_d;
      fault_q <= fault_d;
      ovr_q   <= ovr_d;
    end
  end

  assign pid_start   = (state_q == ST_COMPUTE);
  assign pid_error   = err_q;
  assign duty        = duty_q;
  assign dir         = dir_q;
  assign duty_valid  = dval_q;
  assign sample_tick = tick;
  assign fault       = fault_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_pid_loop_sequencer.sv
// Directed bench for the speed-loop sequencer.
// Vector table for the loop, hand sequences for corner cases.
module tb_pid_loop_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               a_ena, a_done;
  logic signed [15:0] a_sp, a_pu;
  logic        [15:0] a_enc;
  logic               a_start, a_dir, a_dval, a_tick, a_fault;
  logic signed [15:0] a_err;
  logic         [7:0] a_duty, a_ovr;

  logic               b_ena, b_done;
  logic signed [15:0] b_sp, b_pu;
  logic        [15:0] b_enc;
  logic               b_start, b_dir, b_dval, b_tick, b_fault;
  logic signed [15:0] b_err;
  logic         [7:0] b_duty, b_ovr;

  pid_loop_sequencer #(
    .SAMPLE_DIV(100), .CNT_W(16), .DUTY_W(8), .TIMEOUT(16)
  ) u_a (
    .clk(clk), .rst(rst), .ena(a_ena), .setpoint(a_sp),
    .enc_count(a_enc), .pid_start(a_start), .pid_error(a_err),
    .pid_done(a_done), .pid_u(a_pu), .duty(a_duty), .dir(a_dir),
    .duty_valid(a_dval), .sample_tick(a_tick), .fault(a_fault),
    .overrun_cnt(a_ovr)
  );

  pid_loop_sequencer #(
    .SAMPLE_DIV(8), .CNT_W(16), .DUTY_W(8), .TIMEOUT(64)
  ) u_b (
    .clk(clk), .rst(rst), .ena(b_ena), .setpoint(b_sp),
    .enc_count(b_enc), .pid_start(b_start), .pid_error(b_err),
    .pid_done(b_done), .pid_u(b_pu), .duty(b_duty), .dir(b_dir),
    .duty_valid(b_dval), .sample_tick(b_tick), .fault(b_fault),
    .overrun_cnt(b_ovr)
  );

  typedef struct {
    int sp;
    int enc;
    int pu;
    int dly;
    int err;
    int duty;
    int dir;
  } vec_t;

  vec_t tv[8];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance until pid_start; lat = cycles since the last tick.
  task automatic wait_start(input bit sel, output int lat);
    int tk;
    bit ok;
    tk = -1000;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (sel ? b_tick : a_tick) tk = cyc;
      if (sel ? b_start : a_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("start_wait_expired", 0, 1);
    lat = cyc - tk;
  endtask

  initial begin
    int lat;
    int hits;
    int want;

    tv[0] = '{sp:20,     enc:'h0000, pu:-300,   dly:3,  err:20,     duty:255, dir:1};
    tv[1] = '{sp:0,      enc:'hFFF0, pu:100,    dly:1,  err:16,     duty:100, dir:0};
    tv[2] = '{sp:40,     enc:'h0010, pu:100,    dly:5,  err:8,      duty:100, dir:0};
    tv[3] = '{sp:32767,  enc:'hFFAC, pu:-32768, dly:0,  err:32767,  duty:255, dir:1};
    tv[4] = '{sp:-32768, enc:'h0010, pu:0,      dly:2,  err:-32768, duty:0,   dir:0};
    tv[5] = '{sp:-5,     enc:'h0010, pu:-1,     dly:7,  err:-5,     duty:1,   dir:1};
    tv[6] = '{sp:7,      enc:'h0013, pu:255,    dly:14, err:4,      duty:255, dir:0};
    tv[7] = '{sp:0,      enc:'h0013, pu:256,    dly:4,  err:0,      duty:255, dir:0};

    rst = 1'b1;
    a_ena = 0; a_done = 0; a_sp = 0; a_pu = 0; a_enc = 0;
    b_ena = 0; b_done = 0; b_sp = 0; b_pu = 0; b_enc = 0;
    step();
    step();
    chk("reset_flags", int'({a_duty, a_dir, a_dval, a_fault, a_start, a_tick}), 0);
    chk("reset_ovr", int'(a_ovr), 0);
    chk("reset_err", int'(a_err), 0);
    rst = 1'b0;
    a_enc = 16'h0000;
    a_ena = 1'b1;

    for (int i = 0; i < 8; i++) begin
      a_sp  = tv[i].sp[15:0];
      a_enc = tv[i].enc[15:0];
      wait_start(1'b0, lat);
      chk($sformatf("v%0d_tick_to_start", i), lat, 2);
      chk($sformatf("v%0d_pid_error", i), int'(a_err), tv[i].err);
      step();
      repeat (tv[i].dly) step();
      a_done = 1'b1;
      a_pu   = tv[i].pu[15:0];
      step();
      a_done = 1'b0;
      chk($sformatf("v%0d_dval_early", i), int'(a_dval), 0);
      step();
      chk($sformatf("v%0d_dval", i), int'(a_dval), 1);
      chk($sformatf("v%0d_duty", i), int'(a_duty), tv[i].duty);
      chk($sformatf("v%0d_dir", i), int'(a_dir), tv[i].dir);
      step();
      chk($sformatf("v%0d_dval_pulse", i), int'(a_dval), 0);
    end

    // Timeout: no pid_done at all.
    wait_start(1'b0, lat);
    step();
    repeat (15) step();
    chk("fault_before_expiry", int'(a_fault), 0);
    chk("duty_before_expiry", int'(a_duty), 255);
    step();
    chk("fault_set", int'(a_fault), 1);
    chk("fault_duty", int'(a_duty), 0);
    hits = 0;
    for (int i = 0; i < 250; i++) begin
      step();
      if (a_start || a_tick || !a_fault) hits++;
    end
    chk("fault_quiet", hits, 0);
    a_ena = 1'b0;
    step();
    chk("fault_cleared", int'(a_fault), 0);

    // pid_done on the final timeout cycle wins.
    a_ena = 1'b1;
    wait_start(1'b0, lat);
    step();
    repeat (15) step();
    a_done = 1'b1;
    a_pu   = 16'sd50;
    step();
    a_done = 1'b0;
    chk("late_done_no_fault", int'(a_fault), 0);
    step();
    chk("late_done_dval", int'(a_dval), 1);
    chk("late_done_duty", int'(a_duty), 50);

    // Stray pid_done outside WAIT_PID.
    a_done = 1'b1;
    a_pu   = 16'sd77;
    step();
    a_done = 1'b0;
    step();
    step();
    chk("stray_done_dval", int'(a_dval), 0);
    chk("stray_done_duty", int'(a_duty), 50);

    // Asynchronous reset in WAIT_PID, then a primed restart.
    a_sp = 16'sd9;
    wait_start(1'b0, lat);
    step();
    #2 rst = 1'b1;
    #1;
    chk("rst_async_duty", int'(a_duty), 0);
    chk("rst_async_flags", int'({a_dval, a_fault, a_start}), 0);
    a_enc = 16'h1234;
    step();
    rst = 1'b0;
    wait_start(1'b0, lat);
    chk("rst_primed_err", int'(a_err), 9);

    // Overrun: each loop outlasts one sample period.
    b_ena = 1'b1;
    for (int k = 0; k < 260; k++) begin
      wait_start(1'b1, lat);
      if (k == 0) chk("ovr_err", int'(b_err), 0);
      step();
      repeat (10) step();
      want   = 10 * (k % 20 + 1);
      b_done = 1'b1;
      b_pu   = want[15:0];
      step();
      b_done = 1'b0;
      step();
      if (k < 4) begin
        chk($sformatf("ovr%0d_dval", k), int'(b_dval), 1);
        chk($sformatf("ovr%0d_duty", k), int'(b_duty), want);
        chk($sformatf("ovr%0d_cnt", k), int'(b_ovr), k + 1);
      end
      if (k == 259) begin
        chk("ovr_saturated", int'(b_ovr), 255);
        chk("ovr_no_fault", int'(b_fault), 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
